mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU load/store port to a single-beat bus.
// Takes one request at a time from IDLE and checks its alignment. An aligned
// request runs one bus transaction with lane enables and replicated store
// data. Loads return the addressed lane, sign- or zero-extended. A
// misaligned request, or a bus that never acknowledges, ends in a one-cycle
// exception pulse instead of a completion pulse.
// State encoding on dbg_state_o: 0 IDLE, 1 REQ, 2 DONE, 3 ERR.
//
// Handshakes: cpu_req is a level request and is sampled only in IDLE.
// cpu_stall is high while the request is being served, and the result is
// one pulse, either cpu_done or cpu_exc. bus_req is the bus-side valid. It
// holds bus_addr/bus_we/bus_be/bus_wdata stable until bus_ack, the one-cycle
// ready/completion from the slave, is seen in REQ, or until the wait counter
// aborts the access. bus_ack seen in any other state is ignored.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_type,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_exc,
   output logic [1:0]  cpu_exc_code,
   output logic        cpu_stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_e;

   // Last wait-counter value that is still allowed to complete
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;

   // Request fields latched in IDLE
   logic        we_q, we_d;
   logic [2:0]  type_q, type_d;
   logic [1:0]  lane_q, lane_d;

   // Registered outputs
   logic [31:0] rdata_q, rdata_d;
   logic        done_q, done_d;
   logic        exc_q, exc_d;
   logic [1:0]  code_q, code_d;
   logic        breq_q, breq_d;
   logic        bwe_q, bwe_d;
   logic [31:0] baddr_q, baddr_d;
   logic [3:0]  bbe_q, bbe_d;
   logic [31:0] bwdata_q, bwdata_d;

   // Decode of the incoming request
   logic        req_is_half;
   logic        req_is_byte;
   logic        req_misaligned;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;

   // Load path
   logic [31:0] lane_word;
   logic [31:0] load_value;

   // Size, alignment, lane enables and store replication of the CPU request
   always_comb begin
      req_is_half = 1'b0;
      req_is_byte = 1'b0;
      case (cpu_type)
         3'b001, 3'b010: req_is_half = 1'b1;
         3'b011, 3'b100: req_is_byte = 1'b1;
         default:        ;
      endcase
      req_misaligned = 1'b0;
      req_be         = 4'b1111;
      req_wdata      = cpu_wdata;
      if (req_is_byte) begin
         req_be    = 4'b0001 << cpu_addr[1:0];
         req_wdata = {4{cpu_wdata[7:0]}};
      end else if (req_is_half) begin
         req_misaligned = cpu_addr[0];
         req_be         = cpu_addr[1] ? 4'b1100 : 4'b0011;
         req_wdata      = {2{cpu_wdata[15:0]}};
      end else begin
         req_misaligned = (cpu_addr[1:0] != 2'b00);
      end
   end

   // Select the addressed lane of the read word and extend it
   always_comb begin
      lane_word = bus_rdata >> {lane_q, 3'b000};
      case (type_q)
         3'b001:  load_value = {{16{lane_word[15]}}, lane_word[15:0]};
         3'b010:  load_value = {16'h0000, lane_word[15:0]};
         3'b011:  load_value = {{24{lane_word[7]}}, lane_word[7:0]};
         3'b100:  load_value = {24'h000000, lane_word[7:0]};
         default: load_value = bus_rdata;
      endcase
   end

   // State register and wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic, including the bus timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               state_d = req_misaligned ? S_ERR : S_REQ;
               cnt_d   = 8'd0;
            end
         end
         S_REQ: begin
            if (bus_ack) begin
               state_d = S_DONE;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and the latched request fields
   always_comb begin
      done_d   = (state_d == S_DONE);
      exc_d    = (state_d == S_ERR);
      code_d   = 2'b00;
      if (exc_d) begin
         code_d = (state_q == S_IDLE) ? EXC_MISALIGN : EXC_TIMEOUT;
      end
      breq_d   = (state_d == S_REQ);
      we_d     = we_q;
      type_d   = type_q;
      lane_d   = lane_q;
      bwe_d    = bwe_q;
      baddr_d  = baddr_q;
      bbe_d    = bbe_q;
      bwdata_d = bwdata_q;
      if (state_q == S_IDLE && cpu_req) begin
         we_d   = cpu_we;
         type_d = cpu_type;
         lane_d = cpu_addr[1:0];
         if (!req_misaligned) begin
            bwe_d    = cpu_we;
            baddr_d  = {cpu_addr[31:2], 2'b00};
            bbe_d    = req_be;
            bwdata_d = req_wdata;
         end
      end
      rdata_d = rdata_q;
      if (state_q == S_REQ && bus_ack && !we_q) begin
         rdata_d = load_value;
      end
   end

   // Output and request-field registers
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         type_q   <= 3'b000;
         lane_q   <= 2'b00;
         rdata_q  <= 32'd0;
         done_q   <= 1'b0;
         exc_q    <= 1'b0;
         code_q   <= 2'b00;
         breq_q   <= 1'b0;
         bwe_q    <= 1'b0;
         baddr_q  <= 32'd0;
         bbe_q    <= 4'b0000;
         bwdata_q <= 32'd0;
      end else begin
         we_q     <= we_d;
         type_q   <= type_d;
         lane_q   <= lane_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         exc_q    <= exc_d;
         code_q   <= code_d;
         breq_q   <= breq_d;
         bwe_q    <= bwe_d;
         baddr_q  <= baddr_d;
         bbe_q    <= bbe_d;
         bwdata_q <= bwdata_d;
      end
   end

   assign cpu_rdata    = rdata_q;
   assign cpu_done     = done_q;
   assign cpu_exc      = exc_q;
   assign cpu_exc_code = code_q;
   assign cpu_stall    = (state_q == S_REQ) || (state_q == S_IDLE && cpu_req);
   assign bus_req      = breq_q;
   assign bus_we       = bwe_q;
   assign bus_addr     = baddr_q;
   assign bus_be       = bbe_q;
   assign bus_wdata    = bwdata_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl (TIMEOUT = 4): directed cases, then random
// loads/stores checked against a size/offset arithmetic model.
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_exc, cpu_stall;
  logic [1:0]  cpu_exc_code;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata = 32'd0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_exc(cpu_exc),
    .cpu_exc_code(cpu_exc_code), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int size_of(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic is_signed(input logic [2:0] t);
    return (t == 3'd1 || t == 3'd3);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
    int sz = size_of(t);
    int mask = (1 << sz) - 1;
    int off = int'(a % 4);
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] w);
    int sz = size_of(t);
    if (sz == 1) return (w % 256) * 32'h0101_0101;
    if (sz == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] r);
    int sz = size_of(t);
    logic [31:0] v = r / (32'd1 << (int'(a % 4) * 8));
    logic [31:0] lim;
    if (sz == 4) return r;
    lim = (sz == 1) ? 32'd256 : 32'd65536;
    v = v % lim;
    if (is_signed(t) && v >= lim / 2) return v - lim;
    return v;
  endfunction

  // driver: one full CPU access; ack_after = REQ cycles before ack (>= TO: never)
  task automatic do_access(input logic we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] w, input int ack_after, input logic [31:0] rd);
    int sz = size_of(t);
    logic [3:0] be = model_be(t, a);
    logic [31:0] addr_w = a & 32'hFFFF_FFFC;
    cpu_req = 1'b1; cpu_we = we; cpu_type = t; cpu_addr = a; cpu_wdata = w;
    #1;
    check("stall_on_request", {31'd0, cpu_stall}, 32'd1);
    tick();
    cpu_req = 1'b0;
    if ((a % sz) != 0) begin
      check("misalign_exc", {31'd0, cpu_exc}, 32'd1);
      check("misalign_code", {30'd0, cpu_exc_code}, 32'd1);
      check("misalign_no_busreq", {31'd0, bus_req}, 32'd0);
      check("misalign_no_done", {31'd0, cpu_done}, 32'd0);
      check("misalign_stall", {31'd0, cpu_stall}, 32'd0);
      tick();
      check("misalign_exc_pulse", {31'd0, cpu_exc}, 32'd0);
      check("misalign_rdata_kept", cpu_rdata, exp_rdata);
      return;
    end
    check("bus_req_start", {31'd0, bus_req}, 32'd1);
    check("bus_addr", bus_addr, addr_w);
    check("bus_we", {31'd0, bus_we}, {31'd0, we});
    check("bus_be", {28'd0, bus_be}, {28'd0, be});
    if (we) check("bus_wdata", bus_wdata, model_wdata(t, w));
    check("stall_in_req", {31'd0, cpu_stall}, 32'd1);
    for (int k = 0; k < TO; k++) begin
      // junk on the CPU side while busy must be ignored
      cpu_req = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_type = 3'($urandom_range(0, 7));
      if (k == ack_after) begin
        bus_ack = 1'b1; bus_rdata = rd;
        if (!we) exp_rdata = model_load(t, a, rd);
        exp_q.push_back(exp_rdata);
        tick();
        bus_ack = 1'b0; bus_rdata = $urandom;
        check("done_pulse", {31'd0, cpu_done}, 32'd1);
        check("done_no_exc", {31'd0, cpu_exc}, 32'd0);
        check("done_busreq_low", {31'd0, bus_req}, 32'd0);
        check("done_stall_low", {31'd0, cpu_stall}, 32'd0);
        check("cpu_rdata", cpu_rdata, exp_q.pop_front());
        bus_ack = 1'($urandom_range(0, 1));
        tick();
        cpu_req = 1'b0; bus_ack = 1'b0;
        check("done_one_cycle", {31'd0, cpu_done}, 32'd0);
        check("idle_no_exc", {31'd0, cpu_exc}, 32'd0);
        return;
      end else if (k == TO - 1) begin
        tick();
        check("timeout_exc", {31'd0, cpu_exc}, 32'd1);
        check("timeout_code", {30'd0, cpu_exc_code}, 32'd2);
        check("timeout_busreq_low", {31'd0, bus_req}, 32'd0);
        check("timeout_no_done", {31'd0, cpu_done}, 32'd0);
        check("timeout_rdata_kept", cpu_rdata, exp_rdata);
        tick();
        cpu_req = 1'b0;
        check("timeout_exc_pulse", {31'd0, cpu_exc}, 32'd0);
        return;
      end else begin
        tick();
        check("bus_req_held", {31'd0, bus_req}, 32'd1);
        check("bus_addr_stable", bus_addr, addr_w);
        check("bus_be_stable", {28'd0, bus_be}, {28'd0, be});
        check("no_early_done", {31'd0, cpu_done}, 32'd0);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_done"}, {31'd0, cpu_done}, 32'd0);
    check({tag, "_exc"}, {31'd0, cpu_exc}, 32'd0);
    check({tag, "_code"}, {30'd0, cpu_exc_code}, 32'd0);
    check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    check({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    check({tag, "_bus_be"}, {28'd0, bus_be}, 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
  endtask

  // directed steps, random traffic, mid-request reset, report
  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_type = 3'd0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check_reset_values("reset");

    // byte signed load, ack after 2 cycles
    do_access(1'b0, 3'd3, 32'h0000_0103, 32'd0, 2, 32'h80FF_0000);
    check("lb_value", cpu_rdata, 32'hFFFF_FF80);
    // half unsigned load, upper half
    do_access(1'b0, 3'd2, 32'h0000_0202, 32'd0, 0, 32'hBEEF_1234);
    check("lhu_value", cpu_rdata, 32'h0000_BEEF);
    // byte store: replicated data, single lane, rdata untouched
    do_access(1'b1, 3'd4, 32'h0000_0301, 32'h1234_56A5, 1, 32'h5555_5555);
    check("sb_rdata_kept", cpu_rdata, 32'h0000_BEEF);
    // misaligned word load
    do_access(1'b0, 3'd0, 32'h0000_0402, 32'd0, 0, 32'd0);
    // ack in the last permitted cycle still completes
    do_access(1'b0, 3'd0, 32'h0000_0500, 32'd0, TO - 1, 32'hCAFE_F00D);
    check("late_ack_value", cpu_rdata, 32'hCAFE_F00D);
    // no ack at all
    do_access(1'b1, 3'd0, 32'h0000_0600, 32'h0BAD_BEEF, TO, 32'd0);
    // reserved type treated as word; misaligned half
    do_access(1'b0, 3'd7, 32'h0000_0704, 32'd0, 0, 32'h8765_4321);
    do_access(1'b1, 3'd1, 32'h0000_0801, 32'hFFFF_FFFF, 0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                $urandom_range(0, TO), $urandom);
    end

    // reset mid-REQ together with an ack, then a stray ack
    do_access(1'b0, 3'd0, 32'h0000_0900, 32'd0, 0, 32'h1357_9BDF);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_type = 3'd0; cpu_addr = 32'h0000_0A00;
    tick();
    cpu_req = 1'b0;
    check("rst_test_bus_req", {31'd0, bus_req}, 32'd1);
    tick();
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    exp_rdata = 32'd0;
    check_reset_values("mid_req_reset");
    tick();
    bus_ack = 1'b0;
    check_reset_values("after_stray_ack");
    tick();
    check("after_stray_ack_done", {31'd0, cpu_done}, 32'd0);
    // controller still serves requests afterwards
    do_access(1'b0, 3'd1, 32'h0000_0B02, 32'd0, 0, 32'h9ABC_0000);
    check("post_reset_lh", cpu_rdata, 32'hFFFF_9ABC);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
